// File: rtl/bp_pkg.sv
// bp_pkg: shared types, table geometry and counter helper for branch_predictor.
// The BTB entry layout is fixed by BP_PC_W/BP_ENTRIES; branch_predictor rejects mismatched parameters.
package bp_pkg;
    localparam int BP_PC_W    = 12;
    localparam int BP_ENTRIES = 16;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = BP_PC_W - BP_IDX_W - 2;
    typedef enum logic [1:0] {SNT, WNT, WT, ST} ctr_t;
    localparam ctr_t CTR_RST = WNT;
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
    } btb_entry_t;
    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        return taken ? (c == ST ? ST : ctr_t'(c + 2'd1)) : (c == SNT ? SNT : ctr_t'(c - 2'd1));
    endfunction
endpackage

// File: rtl/bp_pht.sv
// bp_pht: pattern history table of 2-bit saturating counters.
// Ports: clk, rst (async, active-high, counters -> WNT); ridx/rctr combinational read;
//        we/widx/wtaken synchronous saturating update.
module bp_pht import bp_pkg::*; #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] ridx,
    output ctr_t             rctr,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic             wtaken
);
    ctr_t pht [ENTRIES];
    assign rctr = pht[ridx];
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < ENTRIES; i++) pht[i] <= CTR_RST;
        else if (we)
            pht[widx] <= ctr_next(pht[widx], wtaken);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus 2-bit PHT giving a same-cycle next-PC prediction.
// Ports: clk, rst (async, active-high); lookup_pc -> pred_hit/pred_taken/pred_next_pc;
//        update_valid/update_pc/update_taken/update_target train the tables.
// Macro BP_GSHARE_EN: adds a GHR XOR-ed into the PHT index plus pred_ghr/update_ghr ports.
module branch_predictor import bp_pkg::*; #(
    parameter int PC_W    = BP_PC_W,
    parameter int ENTRIES = BP_ENTRIES,
    parameter int GHR_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic             pred_hit,
    output logic [PC_W-1:0]  pred_next_pc,
`ifdef BP_GSHARE_EN
    output logic [GHR_W-1:0] pred_ghr,
`endif
    input  logic             update_valid,
    input  logic [PC_W-1:0]  update_pc,
    input  logic             update_taken,
    input  logic [PC_W-1:0]  update_target
`ifdef BP_GSHARE_EN
    ,input logic [GHR_W-1:0] update_ghr
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    if (PC_W != BP_PC_W || ENTRIES != BP_ENTRIES || ENTRIES < 2 || (1 << IDX_W) != ENTRIES) begin : g_bad_geometry
        $error("branch_predictor: PC_W/ENTRIES must match bp_pkg and ENTRIES must be a power of 2");
    end
    btb_entry_t       btb [ENTRIES];
    btb_entry_t       lent;
    logic [IDX_W-1:0] lidx, uidx, lpidx, upidx;
    logic [TAG_W-1:0] ltag, utag;
    ctr_t             lctr;
    logic             unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};
    assign lidx = lookup_pc[IDX_W+1:2];
    assign uidx = update_pc[IDX_W+1:2];
    assign ltag = lookup_pc[PC_W-1:IDX_W+2];
    assign utag = update_pc[PC_W-1:IDX_W+2];
`ifdef BP_GSHARE_EN
    if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr
        $error("branch_predictor: GHR_W must be within 1..IDX_W");
    end
    logic [GHR_W-1:0] ghr;
    // History is rebuilt from the resolved branch's own snapshot, repairing any stale value.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            ghr <= '0;
        else if (update_valid)
            ghr <= GHR_W'({update_ghr, update_taken});
    assign pred_ghr = ghr;
    assign lpidx    = lidx ^ IDX_W'(ghr);
    assign upidx    = uidx ^ IDX_W'(update_ghr);
`else
    assign lpidx = lidx;
    assign upidx = uidx;
`endif
    bp_pht #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_pht (
        .clk   (clk),
        .rst   (rst),
        .ridx  (lpidx),
        .rctr  (lctr),
        .we    (update_valid),
        .widx  (upidx),
        .wtaken(update_taken)
    );
    // Taken updates write the same entry whether they hit (retarget) or miss (allocate/evict).
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
        else if (update_valid && update_taken)
            btb[uidx] <= '{valid: 1'b1, tag: utag, target: update_target};
    assign lent         = btb[lidx];
    assign pred_hit     = lent.valid && lent.tag == ltag;
    assign pred_taken   = pred_hit && lctr[1];
    assign pred_next_pc = pred_taken ? lent.target : lookup_pc + PC_W'(4);
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised fetch-stage branch predictor for the 5-stage RV32 pipeline: a direct-mapped branch target buffer (BTB) plus a pattern history table (PHT) of 2-bit saturating counters. Fetch presents the current PC combinationally and receives the predicted next PC in the same cycle. Decode returns the resolved outcome of each branch so the tables train. It replaces the fixed PC+4 path into the PC mux whenever a confident taken prediction exists.

## Interface
- PC_W, 12: PC width in bits (byte address, word-aligned).
- ENTRIES, 16: BTB and PHT depth; power of 2, at least 2; IDX_W = log2(ENTRIES).
- GHR_W, 4: global history length; must satisfy 1 ≤ GHR_W ≤ IDX_W. Used only with BP_GSHARE_EN.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_pc  in  PC_W  fetch PC (PCim).
- pred_taken  out  1  BTB hit AND counter MSB = 1.
- pred_hit  out  1  BTB entry valid with matching tag.
- pred_next_pc  out  PC_W  pred_taken ? BTB target : lookup_pc+4 (mod 2^PC_W).
- pred_ghr  out  GHR_W  GHR value at lookup; pipeline carries it to update_ghr. Exists only with the macro.
- update_valid  in  1  a conditional branch resolved this cycle.
- update_pc  in  PC_W  PC of the resolved branch.
- update_taken  in  1  resolved direction.
- update_target  in  PC_W  resolved taken target.
- update_ghr  in  GHR_W  pred_ghr captured with this branch. Exists only with the macro.

## Operation
- Indexing:
  - BTB index = pc[IDX_W+1:2].
  - Tag = pc[PC_W-1:IDX_W+2].
  - PHT index = BTB index, or BTB index XOR zero-extended history with the macro.
- Lookup is purely combinational from registered state. There is no bypass from a same-cycle update.
- Update, on a clk edge with update_valid=1:
  - PHT[u_idx] saturating: taken increments (max 3), not-taken decrements (min 0).
  - BTB hit and taken: target overwritten with update_target.
  - BTB miss and taken: allocate. Set valid=1, write tag and target, evicting any prior entry.
  - BTB miss and not-taken: no BTB change.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
- update_valid=0: no state changes.
- Out-of-range lookup_pc+4 wraps modulo 2^PC_W; no overflow flag.

## Timing
- Lookup latency 0 cycles. Update is visible to lookups from the cycle after the update edge.
- Simultaneous lookup and update to the same index: lookup returns pre-update values.
- Back-to-back updates every cycle are supported, including to the same index. Each update sees the previous one.
- Reset, asynchronous and effective mid-operation:
  - All BTB valid bits = 0.
  - All counters = 1 (weak-NT).
  - GHR = 0.
  - Outputs follow immediately: pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4, pred_ghr=0.
- No state changes while rst=1, regardless of update_valid.

## Configuration
- BP_GSHARE_EN defined:
  - GHR_W-bit global history register exists.
  - PHT index = BTB index XOR {0, GHR}; lookup uses the current GHR, update uses update_ghr.
  - On each update, GHR <= {update_ghr[GHR_W-2:0], update_taken}. This is non-speculative, so a stale GHR is repaired at every resolution.
  - pred_ghr and update_ghr ports are present.
- BP_GSHARE_EN undefined:
  - No GHR.
  - PHT index = BTB index (bimodal).
  - pred_ghr and update_ghr ports are absent.

## Structure
- Package bp_pkg holds:
  - Counter typedef (2-bit enum: SNT, WNT, WT, ST) and reset constant WNT.
  - BTB entry struct {valid, tag, target}.
  - Helper function for saturating increment/decrement.
- Sub-module bp_pht: counter array with one combinational read port, one synchronous write port and async reset. The BTB stays inline in branch_predictor.

## Test plan
- Reset, then lookup_pc=0x010 → pred_hit=0, pred_taken=0, pred_next_pc=0x014. Also lookup_pc=0xFFC → pred_next_pc=0x000 (wrap).
- Cold taken branch:
  - One update at pc=0x020, taken, target 0x100.
  - Next cycle lookup 0x020 → hit, counter=2, pred_taken=1, pred_next_pc=0x100.
  - Same-cycle lookup during that update → pred_hit=0.
- Saturation:
  - 4 taken updates at 0x020, then 1 not-taken → counter 2, still predicts taken.
  - 3 more not-taken → counter 0; further not-taken keeps it at 0; hit=1, pred_taken=0.
- Aliasing (ENTRIES=16): train 0x020 taken to 0x100, then update 0x060 (same index, different tag) taken to 0x200 → lookup 0x020 misses, lookup 0x060 hits with target 0x200.
- Asynchronous reset asserted mid-cycle after training → outputs drop to hit=0, next_pc=pc+4 before the next clk edge. A concurrent update_valid is ignored.
- BP_GSHARE_EN, GHR_W=4:
  - Pattern T,N repeated at 0x020 for 16 updates → GHR alternates 0x5/0xA.
  - Lookups with pred_ghr=0xA predict taken, with 0x5 predict not-taken.
